// File: rtl/counter_rr_sched.sv
// counter_rr_sched
// Round-robin front end that hands one grant counter to one of two requesters
// at a time. An ownership lasts up to BURST granted cycles and ends early when
// the owner drops its request. A one-cycle done pulse marks the release, and
// the block then stays idle for GAP cycles before it samples requests again.
// Every output comes straight from a flop: the comb blocks work out next-cycle
// values and a single register process loads them.

module counter_rr_sched #(
  parameter int CNT_W = 5,
  parameter int BURST = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req1,
  input  logic             req2,
  output logic             gnt1,
  output logic             gnt2,
  output logic [CNT_W-1:0] counter,
  output logic             owner,
  output logic             busy,
  output logic             done
);

  // state   | meaning
  // IDLE    | no owner; samples req1/req2 every cycle
  // OWN1    | requester 1 holds the counter
  // OWN2    | requester 2 holds the counter
  // GAP_ST  | enforced idle gap after an ownership; requests are ignored
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN1   = 2'd1,
    OWN2   = 2'd2,
    GAP_ST = 2'd3
  } state_t;

  // Counter value that ends a full burst on the next granted cycle.
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);
  // The gap down-counter is loaded on entry and leaves GAP when it reaches
  // zero, so loading GAP-1 gives exactly GAP cycles in GAP_ST.
  localparam logic [3:0]       GAP_LOAD   = 4'(GAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       gap_q,   gap_d;
  logic             owner_q, owner_d;
  logic             gnt1_q,  gnt1_d;
  logic             gnt2_q,  gnt2_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic             enter_own;
  logic             enter_gap;

  // State register with immediate (asynchronous) reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: arbitration in IDLE, burst / early-release exits, gap timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req1 && req2) begin
          // Both want it: serve the requester that did not own it last.
          state_d = owner_q ? OWN1 : OWN2;
        end else if (req1) begin
          state_d = OWN1;
        end else if (req2) begin
          state_d = OWN2;
        end
      end
      OWN1: begin
        if (!req1 || (cnt_q == BURST_LAST)) begin
          state_d = GAP_ST;
        end
      end
      OWN2: begin
        if (!req2 || (cnt_q == BURST_LAST)) begin
          state_d = GAP_ST;
        end
      end
      GAP_ST: begin
        if (gap_q == 4'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_own = (state_q == IDLE) && ((state_d == OWN1) || (state_d == OWN2));
  assign enter_gap = (state_q != GAP_ST) && (state_d == GAP_ST);

  // Output / datapath logic: next values for counter, gap timer, owner and flags.
  always_comb begin
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    owner_d = owner_q;

    if (enter_own) begin
      cnt_d   = '0;
      owner_d = (state_d == OWN2);
    end else if ((state_q == OWN1) && req1) begin
      cnt_d = cnt_q + 1'b1;
    end else if ((state_q == OWN2) && req2) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (enter_gap) begin
      gap_d = GAP_LOAD;
    end else if ((state_q == GAP_ST) && (gap_q != 4'd0)) begin
      gap_d = gap_q - 4'd1;
    end

    // Flags follow the state being entered so they line up with it in time.
    gnt1_d = (state_d == OWN1);
    gnt2_d = (state_d == OWN2);
    busy_d = (state_d != IDLE);
    done_d = enter_gap;
  end

  // Output and datapath registers; owner resets to 1 so requester 1 wins a first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      gap_q   <= 4'd0;
      owner_q <= 1'b1;
      gnt1_q  <= 1'b0;
      gnt2_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      owner_q <= owner_d;
      gnt1_q  <= gnt1_d;
      gnt2_q  <= gnt2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gnt1    = gnt1_q;
  assign gnt2    = gnt2_q;
  assign counter = cnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_counter_rr_sched.sv
// Directed bench for counter_rr_sched at default parameters (CNT_W=5, BURST=8, GAP=2).
// Inputs change and outputs are sampled on the falling edge; the design acts on the rising edge.

module tb_counter_rr_sched;

  logic       clk;
  logic       rst_n;
  logic       req1;
  logic       req2;
  logic       gnt1;
  logic       gnt2;
  logic [4:0] counter;
  logic       owner;
  logic       busy;
  logic       done;

  int n_chk;
  int n_err;

  counter_rr_sched #(.CNT_W(5), .BURST(8), .GAP(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req1    (req1),
    .req2    (req2),
    .gnt1    (gnt1),
    .gnt2    (gnt2),
    .counter (counter),
    .owner   (owner),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then back to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req1  = 1'b0;
    req2  = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int g1_cnt, g2_cnt, ovl_cnt, done_cnt;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req1  = 1'b1;
    req2  = 1'b1;
    @(negedge clk);

    // 1: reset holds every output quiet even with both requests high.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_gnt1", gnt1, 0);
      chk("rst_gnt2", gnt2, 0);
      chk("rst_counter", counter, 0);
      chk("rst_owner", owner, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end

    // 2: req1 held; full burst, done, gap, one idle cycle, regrant.
    do_reset();
    req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_gnt1", gnt1, 1);
      chk("t2_cnt", counter, i);
      chk("t2_done_low", done, 0);
    end
    step();
    chk("t2_end_gnt1", gnt1, 0);
    chk("t2_end_done", done, 1);
    chk("t2_end_cnt", counter, 8);
    chk("t2_end_busy", busy, 1);
    chk("t2_owner", owner, 0);
    step();
    chk("t2_gap2_done", done, 0);
    chk("t2_gap2_busy", busy, 1);
    chk("t2_gap2_gnt1", gnt1, 0);
    step();
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_gnt1", gnt1, 0);
    chk("t2_idle_cnt", counter, 8);
    step();
    chk("t2_regnt_gnt1", gnt1, 1);
    chk("t2_regnt_cnt", counter, 0);

    // 3: both requests held; alternate owners with gaps, never overlapping.
    do_reset();
    req1 = 1'b1;
    req2 = 1'b1;
    g1_cnt = 0; g2_cnt = 0; ovl_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= 23; c++) begin
      step();
      if (gnt1 && gnt2) ovl_cnt++;
      if (done) done_cnt++;
      if (c <= 19 && gnt1) g1_cnt++;
      if (c <= 19 && gnt2) g2_cnt++;
      if (c == 1) begin
        chk("t3_first_gnt1", gnt1, 1);
        chk("t3_first_owner", owner, 0);
      end
      if (c == 12) begin
        chk("t3_second_gnt2", gnt2, 1);
        chk("t3_second_owner", owner, 1);
      end
      if (c == 23) begin
        chk("t3_third_gnt1", gnt1, 1);
        chk("t3_third_owner", owner, 0);
      end
    end
    chk("t3_gnt1_cycles", g1_cnt, 8);
    chk("t3_gnt2_cycles", g2_cnt, 8);
    chk("t3_overlap", ovl_cnt, 0);
    chk("t3_done_pulses", done_cnt, 2);

    // 4: req2 drops while owned; early release keeps counter at 3.
    do_reset();
    req2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_gnt2", gnt2, 1);
    end
    req2 = 1'b0;
    step();
    chk("t4_rel_gnt2", gnt2, 0);
    chk("t4_rel_done", done, 1);
    chk("t4_rel_cnt", counter, 3);
    chk("t4_owner", owner, 1);
    step();
    chk("t4_gap_cnt", counter, 3);
    chk("t4_gap_busy", busy, 1);
    step();
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_cnt", counter, 3);
    step();
    chk("t4_idle2_cnt", counter, 3);
    chk("t4_idle2_gnt2", gnt2, 0);

    // 5: asynchronous reset in the middle of an ownership.
    do_reset();
    req1 = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t5_pre_cnt", counter, 4);
    chk("t5_pre_gnt1", gnt1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_gnt1", gnt1, 0);
    chk("t5_async_cnt", counter, 0);
    chk("t5_async_owner", owner, 1);
    chk("t5_async_busy", busy, 0);
    req1 = 1'b1;
    req2 = 1'b1;
    #1;
    rst_n = 1'b1;
    step();
    chk("t5_tie_gnt1", gnt1, 1);
    chk("t5_tie_gnt2", gnt2, 0);

    // 6: req2 arriving during GAP is held off until IDLE samples it.
    do_reset();
    req1 = 1'b1;
    step();
    chk("t6_own1", gnt1, 1);
    req1 = 1'b0;
    step();
    chk("t6_gap_done", done, 1);
    chk("t6_gap_cnt", counter, 0);
    req2 = 1'b1;
    step();
    chk("t6_gap_gnt2", gnt2, 0);
    step();
    chk("t6_idle_gnt2", gnt2, 0);
    chk("t6_idle_busy", busy, 0);
    step();
    chk("t6_late_gnt2", gnt2, 1);
    chk("t6_late_owner", owner, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
